// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter: data side and instruction side share one
// memory port. Round-robin on ties, one outstanding access at a time, with a
// bounded wait for mem_ready that reports a timeout through err.
module mem_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_grant;   // 0 = data served last, 1 = instruction
    logic          side;         // requester owning the current transfer
    logic          we_q;
    logic          err_q;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [DW-1:0] i_rdata_q;
    logic          grant_d;
    logic          grant_i;
    logic          timeout_hit;

    // Grant decision and next-state logic; a tie goes to the side not served last
    always_comb begin
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        timeout_hit = 1'b0;
        state_next  = state;
        case (state)
            IDLE: begin
                grant_d = d_req && (!i_req || last_grant);
                grant_i = i_req && !grant_d;
                if (grant_d || grant_i) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // The count reaches TIMEOUT on this cycle if it is one short now
                timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
                if (mem_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus request latching, wait counting and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            side       <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            d_rdata_q  <= '0;
            i_rdata_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        side       <= grant_i;
                        last_grant <= grant_i;
                        we_q       <= grant_d && d_we;
                        addr_q     <= grant_d ? d_addr : i_addr;
                        wdata_q    <= grant_d ? d_wdata : '0;
                        wait_cnt   <= '0;
                        err_q      <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        // A ready in the timeout cycle still completes normally
                        err_q <= 1'b0;
                        if (side) begin
                            i_rdata_q <= we_q ? '0 : mem_rdata;
                        end else begin
                            d_rdata_q <= we_q ? '0 : mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (side) begin
                            i_rdata_q <= '0;
                        end else begin
                            d_rdata_q <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode directly from the state so reset drops them on the same edge
    always_comb begin
        mem_en    = (state == ACCESS);
        mem_we    = (state == ACCESS) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_ack     = (state == RESP) && !side;
        i_ack     = (state == RESP) && side;
        err       = (state == RESP) && err_q;
        busy      = (state != IDLE);
        d_rdata   = d_rdata_q;
        i_rdata   = i_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transfers plus
// hand-written sequences for ties, reset mid-transfer and stray mem_ready.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_req, d_we, i_req;
    logic [AW-1:0] d_addr, i_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack, i_ack, err, mem_en, mem_we, busy;
    logic [DW-1:0] d_rdata, i_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          side;      // 0 = data, 1 = instruction
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          delay;     // ACCESS cycle carrying mem_ready, 0 = never
        logic [31:0] rdata;     // value presented with mem_ready
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_en;    // expected number of mem_en cycles
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] other_before;
        logic [31:0] own_after;
        int          en_cnt;
        bit          hold_bad;
        bit          exp_we;
        other_before = v.side ? d_rdata : i_rdata;
        exp_we = v.side ? 1'b0 : v.we;
        if (v.side) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end
        @(negedge clk);
        chk($sformatf("v%0d latency_mem_en", idx), mem_en, 1);
        // Requester inputs change after grant and must be ignored
        d_addr = ~v.addr; i_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we;
        en_cnt = 0;
        hold_bad = 1'b0;
        while (mem_en === 1'b1 && en_cnt < 40) begin
            en_cnt++;
            if (mem_addr !== v.addr || mem_we !== exp_we) hold_bad = 1'b1;
            if (!v.side && mem_wdata !== v.wdata) hold_bad = 1'b1;
            mem_ready = (en_cnt == v.delay);
            mem_rdata = mem_ready ? v.rdata : $urandom;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        chk($sformatf("v%0d access_hold", idx), hold_bad, 0);
        chk($sformatf("v%0d en_cycles", idx), en_cnt, v.exp_en);
        chk($sformatf("v%0d own_ack", idx), v.side ? i_ack : d_ack, 1);
        chk($sformatf("v%0d other_ack", idx), v.side ? d_ack : i_ack, 0);
        chk($sformatf("v%0d rdata", idx), v.side ? i_rdata : d_rdata, v.exp_rdata);
        chk($sformatf("v%0d err", idx), err, v.exp_err);
        d_req = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        own_after = v.side ? i_rdata : d_rdata;
        chk($sformatf("v%0d ack_pulse", idx), {d_ack, i_ack, busy}, 3'b000);
        chk($sformatf("v%0d rdata_hold", idx), own_after, v.exp_rdata);
        chk($sformatf("v%0d other_rdata_hold", idx), v.side ? d_rdata : i_rdata, other_before);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 10'h004, 32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b1, 10'h3FF, 32'h12345678, 5, 32'hBAD0BAD0, 32'h0,        1'b0, 5};
        vecs[2] = '{1'b1, 1'b0, 10'h123, 32'h0,        2, 32'hA5A50001, 32'hA5A50001, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 10'h2AA, 32'h0,        0, 32'h0,        32'h0,        1'b1, TO};
        vecs[4] = '{1'b0, 1'b0, 10'h200, 32'h0,        3, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3};
        vecs[5] = '{1'b0, 1'b0, 10'h155, 32'h0,        0, 32'h0,        32'h0,        1'b1, TO};
        vecs[6] = '{1'b1, 1'b0, 10'h001, 32'h0,        TO, 32'h11112222, 32'h11112222, 1'b0, TO};
        vecs[7] = '{1'b0, 1'b1, 10'h000, 32'hFFFFFFFF, 1, 32'h55555555, 32'h0,        1'b0, 1};

        rst = 1'b1;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {mem_en, mem_we, d_ack, i_ack, err, busy}, 6'b0);
        chk("reset_rdata", {d_rdata, i_rdata}, 64'h0);
        chk("reset_mem_bus", {mem_addr, mem_wdata}, 64'h0);
        rst = 1'b0;

        // Stray mem_ready while IDLE
        mem_ready = 1'b1;
        mem_rdata = 32'h77777777;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stray_ready_%0d", k), {mem_en, busy, d_ack, i_ack}, 4'b0);
        end
        mem_ready = 1'b0;
        chk("stray_ready_rdata", {d_rdata, i_rdata}, 64'h0);

        // Table of single transfers
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Tie out of reset: data first, then a repeated tie goes to instruction
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        i_req = 1'b1; i_addr = 10'h020;
        @(negedge clk);
        chk("tie1_en", mem_en, 1);
        chk("tie1_addr_data", mem_addr, 10'h010);
        mem_ready = 1'b1; mem_rdata = 32'h0D0D0D0D;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("tie1_acks", {d_ack, i_ack}, 2'b10);
        chk("tie1_d_rdata", d_rdata, 32'h0D0D0D0D);
        d_req = 1'b0;
        @(negedge clk);
        chk("tie_idle_gap", {busy, i_ack}, 2'b00);
        d_req = 1'b1; d_addr = 10'h011;
        @(negedge clk);
        chk("tie2_addr_instr", mem_addr, 10'h020);
        chk("tie2_no_ack", {d_ack, i_ack}, 2'b00);
        mem_ready = 1'b1; mem_rdata = 32'h1E1E1E1E;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("tie2_acks_3_after", {d_ack, i_ack}, 2'b01);
        chk("tie2_i_rdata", i_rdata, 32'h1E1E1E1E);
        i_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("alt3_addr_data", mem_addr, 10'h011);
        mem_ready = 1'b1; mem_rdata = 32'h2F2F2F2F;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("alt3_acks", {d_ack, i_ack}, 2'b10);
        d_req = 1'b0;
        @(negedge clk);

        // Reset in the second ACCESS cycle aborts with no ack
        i_req = 1'b1; i_addr = 10'h055;
        @(negedge clk);
        chk("rstmid_access1", mem_en, 1);
        @(negedge clk);
        chk("rstmid_access2", mem_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_abort", {mem_en, busy, d_ack, i_ack}, 4'b0);
        chk("rstmid_rdata_clear", {d_rdata, i_rdata}, 64'h0);
        rst = 1'b0;
        d_req = 1'b1; d_addr = 10'h0AA;
        @(negedge clk);
        chk("rstmid_tie_data", {mem_en, mem_addr}, {1'b1, 10'h0AA});
        mem_ready = 1'b1; mem_rdata = 32'h13579BDF;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rstmid_d_ack", {d_ack, i_ack, err}, 3'b100);
        chk("rstmid_d_rdata", d_rdata, 32'h13579BDF);
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_then_instr", {mem_en, mem_addr}, {1'b1, 10'h055});
        mem_ready = 1'b1; mem_rdata = 32'h2468ACE0;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rstmid_i_ack", {d_ack, i_ack, err}, 3'b010);
        i_req = 1'b0;
        @(negedge clk);
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 10, address width; DW, default 32, data width; TIMEOUT, default 255, max cycles waiting for mem_ready.
REQ-002 Ports SHALL be, in order:
  clk  in  1  sole clock, rising edge;
  rst  in  1  synchronous, active-high reset;
  d_req  in  1  data-side request (cache refill or write-through);
  d_we  in  1  data-side write (1) / read (0);
  d_addr  in  AW  data-side word address;
  d_wdata  in  DW  data-side write data;
  d_ack  out  1  data-side completion pulse;
  d_rdata  out  DW  data-side read data, valid with d_ack;
  i_req  in  1  instruction-side read request;
  i_addr  in  AW  instruction-side word address;
  i_ack  out  1  instruction-side completion pulse;
  i_rdata  out  DW  instruction-side read data, valid with i_ack;
  err  out  1  timeout flag, valid with d_ack/i_ack;
  mem_en  out  1  main-memory access strobe;
  mem_we  out  1  main-memory write enable;
  mem_addr  out  AW  main-memory address;
  mem_wdata  out  DW  main-memory write data;
  mem_rdata  in  DW  main-memory read data;
  mem_ready  in  1  main-memory completion, one-cycle pulse;
  busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, ACCESS and RESP, plus a 1-bit last_grant register (0 = data, 1 = instruction).
REQ-004 IDLE: if exactly one of d_req/i_req is high, that requester SHALL be granted; if both are high, the requester not named by last_grant SHALL be granted (round-robin); the next state SHALL be ACCESS.
REQ-005 On grant, the arbiter SHALL latch the address, write-enable (forced to 0 for the instruction side) and write data, and SHALL update last_grant; later changes on the requester inputs SHALL be ignored until that requester's ack.
REQ-006 ACCESS: mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL drive the latched values, held stable until mem_ready is sampled high.
REQ-007 When mem_ready is sampled high in ACCESS, the arbiter SHALL register mem_rdata (zero for writes) and go to RESP.
REQ-008 RESP: exactly one of d_ack/i_ack SHALL be 1 for exactly one cycle, with the matching rdata valid; the next state SHALL be IDLE.
REQ-009 rdata outputs SHALL hold their value until the next ack on the same side.
REQ-010 Minimum latency: req sampled at edge N gives mem_en high in cycle N+1; mem_ready in that cycle gives ack in cycle N+2.
REQ-011 A requester SHALL deassert req at the edge that samples its ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-012 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ready; when it reaches TIMEOUT, the arbiter SHALL go to RESP with err=1 and rdata=0, and mem_en SHALL drop.
REQ-013 err SHALL be 0 on every ack that is not caused by a timeout.
REQ-014 A mem_ready arriving outside ACCESS SHALL be ignored.
REQ-015 Arbitration SHALL be evaluated only in IDLE; a request arriving during ACCESS/RESP SHALL wait, and its ack SHALL never coincide with the other side's ack.
REQ-016 Under continuous requests from both sides, grants SHALL strictly alternate d, i, d, i ...

Reset
REQ-017 With rst high at a clock edge, the arbiter SHALL enter IDLE and set last_grant=1 (data wins the first tie).
REQ-018 With rst high at a clock edge, the arbiter SHALL clear the wait counter, mem_en, mem_we, d_ack, i_ack, err, busy, d_rdata, i_rdata, mem_addr and mem_wdata to 0.
REQ-019 A reset during ACCESS or RESP SHALL abort the transfer with no ack, and mem_en SHALL be low in the cycle after the reset edge.

Verification
REQ-020 Data read: d_req=1, d_addr=0x04, mem_rdata=0xDEADBEEF with mem_ready in the first ACCESS cycle -> d_ack=1 two cycles after req, d_rdata=0xDEADBEEF, err=0, i_ack=0.
REQ-021 Tie: d_req and i_req rise together out of reset -> data granted first (mem_addr=d_addr), i_ack follows 3+ cycles after d_ack; a repeated tie then grants instruction first.
REQ-022 Write-through: d_we=1, d_addr=0x3FF, d_wdata=0x12345678, mem_ready after 5 cycles -> mem_en held 5 cycles with mem_we=1, mem_wdata stable, then d_ack pulse with d_rdata=0.
REQ-023 Timeout: TIMEOUT=8, i_req=1, mem_ready never asserted -> mem_en high 8 cycles, then i_ack=1, err=1, i_rdata=0, state IDLE.
REQ-024 Reset mid-access: rst=1 in the 2nd ACCESS cycle -> no ack, mem_en=0 and busy=0 the next cycle; a subsequent tie grants data.
REQ-025 Stray mem_ready while IDLE -> no ack and no state change.
